l1_cmd_sequencer: RTL and testbench

- Initiator side of the L1 cache command interface: buffers trace commands from the trace loader and issues them one at a time to the L1 cache over the write/processing handshake.
- After the trace ends, sweeps the cache's set-read port to dump every set for the final report.
- Sits between the trace loader and the L1 instruction/data cache in the simulation top.

---
 rtl/l1_cmd_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_l1_cmd_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cmd_sequencer.sv
// l1_cmd_sequencer: buffers trace commands, issues them one at a time to the
// L1 cache over the write/processing handshake, then sweeps the set-read port
// to dump every set once the trace has ended.
module l1_cmd_sequencer #(
  parameter int unsigned ADDR_W     = 60,
  parameter int unsigned SET_W      = 14,
  parameter int unsigned NUM_SETS   = 16000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_command,
  input  logic [ADDR_W-1:0] in_address,
  input  logic              trace_end,
  output logic              cache_write,
  output logic [2:0]        cache_command,
  output logic [ADDR_W-1:0] cache_address,
  input  logic              cache_processing,
  output logic [SET_W-1:0]  cache_set_read,
  output logic              dump_valid,
  output logic [SET_W-1:0]  dump_set,
  output logic [31:0]       issued_cnt,
  output logic [31:0]       dropped_cnt,
  output logic              err,
  output logic              done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0]       LAST_CMD = 3'd4;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0]        command;
    logic [ADDR_W-1:0] address;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    ERROR     = 3'd4,
    DUMP      = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t           state;
  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic active;
  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic push;
  logic pop;

  // Loader handshake: accepted only in command-issuing states with room left
  assign active     = (state == IDLE) || (state == ISSUE) ||
                      (state == WAIT_ACK) || (state == WAIT_DONE);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign in_ready   = active && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && (in_command <= LAST_CMD);
  assign pop        = (state == ISSUE);

  // Command storage; contents need no reset since occupancy guards every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{command: in_command, address: in_address};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave it unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sequencer FSM with registered cache-side outputs, counters and dump sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cache_write    <= 1'b0;
      cache_command  <= '0;
      cache_address  <= '0;
      cache_set_read <= '0;
      dump_valid     <= 1'b0;
      dump_set       <= '0;
      issued_cnt     <= '0;
      dropped_cnt    <= '0;
      err            <= 1'b0;
      done           <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      cache_write <= 1'b0;
      // The cache registers its way outputs one cycle after sampling the index
      dump_valid  <= (state == DUMP);
      if (state == DUMP) dump_set <= cache_set_read;
      if (accept && !push) dropped_cnt <= dropped_cnt + 32'd1;

      case (state)
        IDLE: begin
          if (!fifo_empty && !cache_processing) begin
            state <= ISSUE;
          end else if (fifo_empty && trace_end && !cache_processing) begin
            state          <= DUMP;
            cache_set_read <= '0;
          end
        end
        ISSUE: begin
          cache_write   <= 1'b1;
          cache_command <= fifo_mem[rd_ptr].command;
          cache_address <= fifo_mem[rd_ptr].address;
          tmo_cnt       <= '0;
          state         <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            state <= ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (cache_processing) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A completion seen on the last allowed cycle still counts as success
          if (!cache_processing) begin
            issued_cnt <= issued_cnt + 32'd1;
            state      <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            state <= ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        DUMP: begin
          if (cache_set_read == LAST_SET) begin
            state <= DONE;
          end else begin
            cache_set_read <= cache_set_read + SET_W'(1);
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_cmd_sequencer.sv
// Testbench for l1_cmd_sequencer: directed vector table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_l1_cmd_sequencer;

  localparam int unsigned ADDR_W     = 60;
  localparam int unsigned SET_W      = 14;
  localparam int unsigned NUM_SETS   = 4;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned TIMEOUT    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_command;
  logic [ADDR_W-1:0] in_address;
  logic              trace_end;
  logic              cache_write;
  logic [2:0]        cache_command;
  logic [ADDR_W-1:0] cache_address;
  logic              cache_processing;
  logic [SET_W-1:0]  cache_set_read;
  logic              dump_valid;
  logic [SET_W-1:0]  dump_set;
  logic [31:0]       issued_cnt;
  logic [31:0]       dropped_cnt;
  logic              err;
  logic              done;

  always #5 clk = ~clk;

  l1_cmd_sequencer #(
    .ADDR_W(ADDR_W), .SET_W(SET_W), .NUM_SETS(NUM_SETS),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_command(in_command), .in_address(in_address),
    .trace_end(trace_end),
    .cache_write(cache_write), .cache_command(cache_command),
    .cache_address(cache_address), .cache_processing(cache_processing),
    .cache_set_read(cache_set_read),
    .dump_valid(dump_valid), .dump_set(dump_set),
    .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt),
    .err(err), .done(done)
  );

  typedef struct packed {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  typedef struct {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
    int                exp_pulses;
    int                exp_issued;
    int                exp_dropped;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: expected issue order and occupancy since last reset
  cmd_t mdl_q[$];
  int   mdl_occ  = 0;
  int   mdl_enq  = 0;
  int   mdl_drop = 0;
  int   n_strobes = 0;
  int   last_strobe_cyc = 0;
  int   strobe_run = 0;
  bit   chk_ready = 1'b0;

  // Cache model knobs and state
  int cm_lat = 1;
  int cm_len = 3;
  bit cm_stuck = 1'b0;
  bit cm_force_busy = 1'b0;
  int cm_wait = 0;
  int cm_hold = 0;
  bit cm_prev_write = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: account handshake, advance the cache model, check strobes
  task automatic step();
    bit                hs;
    bit                was_rst;
    bit                p;
    logic [2:0]        c;
    logic [ADDR_W-1:0] a;
    cmd_t              e;
    hs      = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst === 1'b0);
    was_rst = (rst === 1'b1);
    c       = in_command;
    a       = in_address;
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      mdl_q.delete();
      mdl_occ = 0; mdl_enq = 0; mdl_drop = 0;
      cm_wait = 0; cm_hold = 0; cm_prev_write = 1'b0;
      strobe_run = 0;
      cache_processing = cm_force_busy;
    end else begin
      if (hs) begin
        if (c <= 3'd4) begin
          mdl_q.push_back('{cmd: c, addr: a});
          mdl_occ++;
          mdl_enq++;
        end else begin
          mdl_drop++;
        end
      end
      if (cm_prev_write) begin
        cm_wait = cm_lat - 1;
        cm_hold = cm_stuck ? 32'h4000_0000 : cm_len;
      end
      p = 1'b0;
      if (cm_wait > 0) cm_wait--;
      else if (cm_hold > 0) begin cm_hold--; p = 1'b1; end
      cache_processing = p || cm_force_busy;
      cm_prev_write = (cache_write === 1'b1);
      if (cache_write === 1'b1) begin
        n_strobes++;
        last_strobe_cyc = cyc;
        strobe_run++;
        check("strobe_width", 64'(strobe_run), 64'd1);
        checks++;
        if (mdl_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: got cmd %0d addr 0x%0h, expected no strobe", cache_command, cache_address);
        end else begin
          e = mdl_q.pop_front();
          mdl_occ--;
          check("strobe_cmd", 64'(cache_command), 64'(e.cmd));
          check("strobe_addr", 64'(cache_address), 64'(e.addr));
        end
      end else begin
        strobe_run = 0;
      end
      if (chk_ready) check("in_ready", 64'(in_ready), 64'(mdl_occ < int'(FIFO_DEPTH)));
    end
  endtask

  // Wait for the model to report all work finished, then let counters settle
  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while ((mdl_occ != 0 || cm_prev_write || cm_wait > 0 || cm_hold > 0 ||
            cache_processing) && k < max_cyc) begin
      step();
      k++;
    end
    if (k >= max_cyc) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", mdl_occ);
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t vt[8];
  int   sr[16];
  int   dv[16];
  int   ds[16];
  int   dn[16];
  int   rdy[16];

  initial begin
    int   k, f, n0, acc, s, issued0;
    bit   r;
    logic [ADDR_W-1:0] ra;

    vt[0] = '{3'd0, 60'h0_0000_0012_3440, 1, 1, 0};
    vt[1] = '{3'd5, 60'h0_0000_0000_0AAA, 0, 1, 1};
    vt[2] = '{3'd1, 60'hF_FFFF_FFFF_FFFF, 1, 2, 1};
    vt[3] = '{3'd2, 60'h0_0000_0000_0000, 1, 3, 1};
    vt[4] = '{3'd6, 60'h0_0000_0000_0005, 0, 3, 2};
    vt[5] = '{3'd3, 60'h8_0000_0000_0000, 1, 4, 2};
    vt[6] = '{3'd7, 60'h1_2345_6789_ABCD, 0, 4, 3};
    vt[7] = '{3'd4, 60'h5_5555_5555_5555, 1, 5, 3};

    rst = 1'b1; in_valid = 1'b0; in_command = '0; in_address = '0;
    trace_end = 1'b0; cache_processing = 1'b0;

    // Reset state
    do_reset();
    check("rst_cache_write", 64'(cache_write), 64'd0);
    check("rst_cache_command", 64'(cache_command), 64'd0);
    check("rst_cache_address", 64'(cache_address), 64'd0);
    check("rst_set_read", 64'(cache_set_read), 64'd0);
    check("rst_dump", 64'({dump_valid, dump_set}), 64'd0);
    check("rst_counts", {issued_cnt, dropped_cnt}, 64'd0);
    check("rst_err_done", 64'({err, done}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    chk_ready = 1'b1;

    // Vector table: single commands, including unsupported codes
    for (int i = 0; i < 8; i++) begin
      n0 = n_strobes;
      check("tbl_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_command = vt[i].cmd; in_address = vt[i].addr;
      step();
      in_valid = 1'b0;
      repeat (20) step();
      check("tbl_pulses", 64'(n_strobes - n0), 64'(vt[i].exp_pulses));
      if (vt[i].exp_pulses == 1) begin
        check("tbl_cmd_hold", 64'(cache_command), 64'(vt[i].cmd));
        check("tbl_addr_hold", 64'(cache_address), 64'(vt[i].addr));
      end
      check("tbl_issued", 64'(issued_cnt), 64'(vt[i].exp_issued));
      check("tbl_dropped", 64'(dropped_cnt), 64'(vt[i].exp_dropped));
    end

    // Nine back-to-back pushes while the cache is busy
    issued0 = issued_cnt;
    n0 = n_strobes;
    cm_force_busy = 1'b1;
    step();
    acc = 0; k = 0;
    while (acc < 8 && k < 20) begin
      in_valid = 1'b1; in_command = 3'(acc % 5); in_address = ADDR_W'(64'h100 * (acc + 1));
      r = in_ready;
      step();
      if (r) acc++;
      k++;
    end
    in_command = 3'd3; in_address = ADDR_W'(64'h900);
    check("b2b_accepted", 64'(acc), 64'd8);
    check("b2b_full", 64'(in_ready), 64'd0);
    step(); step();
    check("b2b_full_hold", 64'(in_ready), 64'd0);
    check("b2b_no_issue", 64'(n_strobes - n0), 64'd0);
    cm_force_busy = 1'b0;
    k = 0; r = 1'b0;
    while (!r && k < 40) begin
      r = in_ready;
      step();
      k++;
    end
    in_valid = 1'b0;
    check("b2b_ninth_accepted", 64'(r), 64'd1);
    drain(300);
    check("b2b_strobes", 64'(n_strobes - n0), 64'd9);
    check("b2b_issued", 64'(issued_cnt - issued0), 64'd9);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_command = 3'($urandom_range(0, 7));
      ra         = ADDR_W'({$urandom(), $urandom()});
      in_address = ra;
      cm_lat     = $urandom_range(1, 3);
      cm_len     = $urandom_range(1, 5);
      step();
    end
    in_valid = 1'b0;
    drain(400);
    check("rand_issued", 64'(issued_cnt), 64'(mdl_enq));
    check("rand_dropped", 64'(dropped_cnt), 64'(mdl_drop));
    check("rand_err", 64'(err), 64'd0);
    cm_lat = 1; cm_len = 3;

    // Handshake timeout with the cache stuck busy
    do_reset();
    chk_ready = 1'b0;
    cm_stuck = 1'b1;
    n0 = n_strobes;
    in_valid = 1'b1; in_command = 3'd1; in_address = ADDR_W'(64'hBEEF0);
    step();
    in_valid = 1'b0;
    k = 0;
    while (n_strobes == n0 && k < 10) begin step(); k++; end
    check("tmo_strobe", 64'(n_strobes - n0), 64'd1);
    s = last_strobe_cyc;
    k = 0;
    while (err !== 1'b1 && k < 40) begin step(); k++; end
    check("tmo_latency", 64'(cyc - s), 64'(TIMEOUT));
    n0 = n_strobes;
    in_valid = 1'b1; in_command = 3'd0; in_address = ADDR_W'(64'h40);
    repeat (10) step();
    check("tmo_stall", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    repeat (10) step();
    check("tmo_no_write", 64'(n_strobes - n0), 64'd0);
    check("tmo_err_hold", 64'({err, done}), 64'b10);
    cm_stuck = 1'b0;

    // Reset while waiting for the cache to finish
    do_reset();
    chk_ready = 1'b1;
    cm_len = 12;
    n0 = n_strobes;
    in_valid = 1'b1; in_command = 3'd2; in_address = ADDR_W'(64'h777);
    step();
    in_command = 3'd3; in_address = ADDR_W'(64'h888);
    step();
    in_valid = 1'b0;
    k = 0;
    while (n_strobes == n0 && k < 10) begin step(); k++; end
    repeat (3) step();
    check("rwd_busy", 64'(cache_processing), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rwd_outputs", 64'({cache_write, cache_command, err, done, dump_valid}), 64'd0);
    check("rwd_address", 64'(cache_address), 64'd0);
    check("rwd_sets", 64'({cache_set_read, dump_set}), 64'd0);
    check("rwd_counts", {issued_cnt, dropped_cnt}, 64'd0);
    n0 = n_strobes;
    repeat (10) step();
    check("rwd_fifo_empty", 64'(n_strobes - n0), 64'd0);
    check("rwd_in_ready", 64'(in_ready), 64'd1);
    cm_len = 3;

    // Post-trace dump sweep
    chk_ready = 1'b0;
    n0 = n_strobes;
    trace_end = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 2) trace_end = 1'b0;
      sr[i] = cache_set_read; dv[i] = dump_valid; ds[i] = dump_set;
      dn[i] = done; rdy[i] = in_ready;
    end
    f = -1;
    for (int i = 15; i >= 0; i--) if (dv[i] == 1) f = i;
    if (f < 1 || f > 10) begin
      checks++; errors++;
      $display("FAIL dump_window: got first dump_valid at %0d, expected 1..10", f);
    end else begin
      for (int j = 0; j < 4; j++) begin
        check("dump_valid", 64'(dv[f + j]), 64'd1);
        check("dump_set", 64'(ds[f + j]), 64'(j));
        check("dump_set_read", 64'(sr[f + j - 1]), 64'(j));
      end
      check("dump_valid_end", 64'(dv[f + 4]), 64'd0);
      check("dump_done_late", 64'(dn[f + 3]), 64'd0);
      check("dump_done", 64'(dn[f + 4]), 64'd1);
      check("dump_in_ready", 64'(rdy[f]), 64'd0);
    end
    repeat (10) step();
    check("done_hold", 64'({done, dump_valid, err}), 64'b100);
    check("dump_no_write", 64'(n_strobes - n0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
